// File: rtl/ref_force_acc_pkg.sv
// Shared types and arithmetic for the reference-force accumulator bank.
package ref_force_acc_pkg;

  localparam int DEF_ID_WIDTH  = 16;
  localparam int DEF_ACC_WIDTH = 40;
  // Widest accumulator the saturating adder supports.
  localparam int SAT_MAX_W     = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } flush_state_t;

  // Write-back entry at the default widths; the bank builds its own
  // entry type with the same field order from its parameters.
  typedef struct packed {
    logic [DEF_ID_WIDTH-1:0]         id;
    logic signed [DEF_ACC_WIDTH-1:0] fx;
    logic signed [DEF_ACC_WIDTH-1:0] fy;
    logic signed [DEF_ACC_WIDTH-1:0] fz;
    logic                            ovf;
  } acc_entry_t;

  // Adds two sign-extended operands and clamps the sum to the signed range
  // of an acc_w-bit accumulator; clamped reports that the clamp engaged.
  function automatic logic signed [SAT_MAX_W-1:0] sat_add(
    input  logic signed [SAT_MAX_W-1:0] acc,
    input  logic signed [SAT_MAX_W-1:0] inc,
    input  int                          acc_w,
    output logic                        clamped
  );
    logic signed [SAT_MAX_W:0] sum;
    logic signed [SAT_MAX_W:0] one;
    logic signed [SAT_MAX_W:0] hi;
    logic signed [SAT_MAX_W:0] lo;
    logic signed [SAT_MAX_W:0] res;
    one = {{SAT_MAX_W{1'b0}}, 1'b1};
    sum = $signed({acc[SAT_MAX_W-1], acc}) + $signed({inc[SAT_MAX_W-1], inc});
    hi  = (one <<< (acc_w - 1)) - one;
    lo  = -(one <<< (acc_w - 1));
    clamped = 1'b0;
    res     = sum;
    if (sum > hi) begin
      res     = hi;
      clamped = 1'b1;
    end else if (sum < lo) begin
      res     = lo;
      clamped = 1'b1;
    end
    return res[SAT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/ref_force_acc_bank_wb_fifo.sv
// Show-ahead write-back FIFO: the head entry is always presented from the
// storage registers, push and pop may coincide, and a push is only taken
// when the pre-pop count leaves room.
module wb_fifo
  import ref_force_acc_pkg::*;
#(
  parameter type entry_t = acc_entry_t,
  parameter int  DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   ready,
  output logic                   valid,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign valid   = (count != '0);
  assign do_pop  = valid && ready;
  assign do_push = push && (count < CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/ref_force_acc_bank.sv
// Per-lane reference-force accumulator bank. Each slot sums partial forces
// for one reference particle and is evicted to the write-back FIFO when the
// particle changes or when a flush sweeps every slot.
// Handshakes: a word moves on a channel only in a cycle where both valid
// and ready are high; valid never depends on ready, and ready here is a
// combinational function of bank state only.
module ref_force_acc_bank
  import ref_force_acc_pkg::*;
#(
  parameter int NUM_SLOTS  = 7,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 40,
  parameter int ID_WIDTH   = 16,
  parameter int WB_DEPTH   = 8,
  parameter int SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SLOT_W-1:0]            in_slot,
  input  logic [ID_WIDTH-1:0]          in_particle_id,
  input  logic signed [DATA_WIDTH-1:0] in_force_x,
  input  logic signed [DATA_WIDTH-1:0] in_force_y,
  input  logic signed [DATA_WIDTH-1:0] in_force_z,
  input  logic                         flush,
  output logic                         flush_busy,
  output logic                         flush_done,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ID_WIDTH-1:0]          out_particle_id,
  output logic signed [ACC_WIDTH-1:0]  out_force_x,
  output logic signed [ACC_WIDTH-1:0]  out_force_y,
  output logic signed [ACC_WIDTH-1:0]  out_force_z,
  output logic                         out_overflow
);

  localparam int                CNT_W     = $clog2(WB_DEPTH) + 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  typedef struct packed {
    logic [ID_WIDTH-1:0]         id;
    logic signed [ACC_WIDTH-1:0] fx;
    logic signed [ACC_WIDTH-1:0] fy;
    logic signed [ACC_WIDTH-1:0] fz;
    logic                        ovf;
  } entry_t;

  entry_t               slot_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] occ_q;
  flush_state_t         state_q;
  logic [SLOT_W-1:0]    k_q;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full;
  logic                 xfer;
  logic                 slot_ok;
  logic [SLOT_W-1:0]    idx;
  entry_t               cur;
  entry_t               upd;
  entry_t               push_data;
  entry_t               head;
  logic                 push;
  logic                 cx, cy, cz;

  // Full uses the pre-pop count so a same-cycle pop never admits extra input.
  assign fifo_full = (fifo_count == CNT_W'(WB_DEPTH));
  assign in_ready  = !flush_busy && !fifo_full;
  assign xfer      = in_valid && in_ready;
  assign slot_ok   = (int'(in_slot) < NUM_SLOTS);
  assign idx       = slot_ok ? in_slot : '0;
  assign cur       = slot_q[idx];

  // New contents of the addressed slot: fresh load, or saturating sum for the same particle.
  always_comb begin
    logic signed [SAT_MAX_W-1:0] sx, sy, sz;
    sx = sat_add(SAT_MAX_W'($signed(cur.fx)), SAT_MAX_W'($signed(in_force_x)), ACC_WIDTH, cx);
    sy = sat_add(SAT_MAX_W'($signed(cur.fy)), SAT_MAX_W'($signed(in_force_y)), ACC_WIDTH, cy);
    sz = sat_add(SAT_MAX_W'($signed(cur.fz)), SAT_MAX_W'($signed(in_force_z)), ACC_WIDTH, cz);
    upd.id  = in_particle_id;
    upd.fx  = ACC_WIDTH'($signed(in_force_x));
    upd.fy  = ACC_WIDTH'($signed(in_force_y));
    upd.fz  = ACC_WIDTH'($signed(in_force_z));
    upd.ovf = 1'b0;
    if (occ_q[idx] && (cur.id == in_particle_id)) begin
      upd.fx  = ACC_WIDTH'(sx);
      upd.fy  = ACC_WIDTH'(sy);
      upd.fz  = ACC_WIDTH'(sz);
      upd.ovf = cur.ovf | cx | cy | cz;
    end
  end

  // Write-back source: an eviction (only possible outside a sweep) or the sweep's current slot.
  always_comb begin
    push      = 1'b0;
    push_data = slot_q[k_q];
    if (xfer && slot_ok && occ_q[idx] && (cur.id != in_particle_id)) begin
      push      = 1'b1;
      push_data = cur;
    end else if ((state_q == SWEEP) && occ_q[k_q] && !fifo_full) begin
      push = 1'b1;
    end
  end

  // Slot updates plus the flush FSM; a sweep step advances unless its slot must wait for FIFO room.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q      <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
      state_q    <= IDLE;
      k_q        <= '0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      if (xfer && slot_ok) begin
        slot_q[idx] <= upd;
        occ_q[idx]  <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (flush) begin
            state_q    <= SWEEP;
            k_q        <= '0;
            flush_busy <= 1'b1;
          end
        end
        SWEEP: begin
          if (!occ_q[k_q] || !fifo_full) begin
            occ_q[k_q]  <= 1'b0;
            slot_q[k_q] <= '0;
            if (k_q == LAST_SLOT) begin
              state_q    <= DONE;
              flush_busy <= 1'b0;
              flush_done <= 1'b1;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  wb_fifo #(
    .entry_t (entry_t),
    .DEPTH   (WB_DEPTH)
  ) u_wb_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .ready     (out_ready),
    .valid     (out_valid),
    .head      (head),
    .count     (fifo_count)
  );

  assign out_particle_id = head.id;
  assign out_force_x     = head.fx;
  assign out_force_y     = head.fy;
  assign out_force_z     = head.fz;
  assign out_overflow    = head.ovf;

endmodule
